// File: rtl/mem2axi_pkg.sv
// Shared definitions for the memory <-> AXI4-Lite bridges.
// Holds the AXI response encodings, the channel widths and the one-hot
// state encoding of the master-side bridge FSM.
package mem2axi_pkg;

  // AXI4-Lite channel widths that do not depend on the bus parameters
  localparam int unsigned RESP_WIDTH  = 2;
  localparam int unsigned STATE_WIDTH = 6;

  // BRESP / RRESP encodings, shared with the slave-side memory bridge
  typedef enum logic [RESP_WIDTH-1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Bit positions of the one-hot state vector
  localparam int unsigned ST_IDLE    = 0;
  localparam int unsigned ST_WR_REQ  = 1;
  localparam int unsigned ST_WR_RESP = 2;
  localparam int unsigned ST_RD_REQ  = 3;
  localparam int unsigned ST_RD_RESP = 4;
  localparam int unsigned ST_CLI_RSP = 5;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE    = STATE_WIDTH'(1) << ST_IDLE,
    S_WR_REQ  = STATE_WIDTH'(1) << ST_WR_REQ,
    S_WR_RESP = STATE_WIDTH'(1) << ST_WR_RESP,
    S_RD_REQ  = STATE_WIDTH'(1) << ST_RD_REQ,
    S_RD_RESP = STATE_WIDTH'(1) << ST_RD_RESP,
    S_CLI_RSP = STATE_WIDTH'(1) << ST_CLI_RSP
  } state_e;

endpackage

// File: rtl/mem2axi.sv
// mem2axi: AXI4-Lite master bridge.
// Turns a single-beat memory-style request/response interface into
// AXI4-Lite AW/W/B (write) or AR/R (read) transactions, one at a time.
//
// Ports
//   i_w_aclk, i_w_areset_n        clock, synchronous active-low reset
//   i_w_req_*/o_w_req_ready       client request (we, addr, wdata)
//   o_w_rsp_*/i_w_rsp_ready       client response (we echo, rdata, resp)
//   AW/W/B, AR/R                  AXI4-Lite master channels
//
// Configuration
//   MEM2AXI_WSTRB_EN  adds i_w_req_wstrb / o_w_wstrb; without it the slave
//                     treats the missing WSTRB as all-ones.
//
// DATA_WIDTH must be 32 or 64. Every output is a register or a decode of
// the one-hot state; no AXI input reaches an AXI output combinationally.
module mem2axi
  import mem2axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_w_aclk,
  input  logic                  i_w_areset_n,
  // client request
  input  logic                  i_w_req_valid,
  output logic                  o_w_req_ready,
  input  logic                  i_w_req_we,
  input  logic [ADDR_WIDTH-1:0] i_w_req_addr,
  input  logic [DATA_WIDTH-1:0] i_w_req_wdata,
`ifdef MEM2AXI_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] i_w_req_wstrb,
`endif
  // client response
  output logic                  o_w_rsp_valid,
  input  logic                  i_w_rsp_ready,
  output logic                  o_w_rsp_we,
  output logic [DATA_WIDTH-1:0] o_w_rsp_rdata,
  output logic [RESP_WIDTH-1:0] o_w_rsp_resp,
  // AW channel
  output logic                  o_w_awvalid,
  input  logic                  i_w_awready,
  output logic [ADDR_WIDTH-1:0] o_w_awaddr,
  // W channel
  output logic                  o_w_wvalid,
  input  logic                  i_w_wready,
  output logic [DATA_WIDTH-1:0] o_w_wdata,
`ifdef MEM2AXI_WSTRB_EN
  output logic [DATA_WIDTH/8-1:0] o_w_wstrb,
`endif
  // B channel
  input  logic                  i_w_bvalid,
  output logic                  o_w_bready,
  input  logic [RESP_WIDTH-1:0] i_w_bresp,
  // AR channel
  output logic                  o_w_arvalid,
  input  logic                  i_w_arready,
  output logic [ADDR_WIDTH-1:0] o_w_araddr,
  // R channel
  input  logic                  i_w_rvalid,
  output logic                  o_w_rready,
  input  logic [RESP_WIDTH-1:0] i_w_rresp,
  input  logic [DATA_WIDTH-1:0] i_w_rdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state, state_nxt;
  logic                    aw_pend, aw_pend_nxt;
  logic                    w_pend, w_pend_nxt;
  logic                    we_q, we_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_nxt;
  logic [RESP_WIDTH-1:0]   resp_q, resp_nxt;
`ifdef MEM2AXI_WSTRB_EN
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_nxt;
`endif

  // State and datapath registers
  always_ff @(posedge i_w_aclk) begin
    if (!i_w_areset_n) begin
      state   <= S_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
`ifdef MEM2AXI_WSTRB_EN
      wstrb_q <= '0;
`endif
    end else begin
      state   <= state_nxt;
      aw_pend <= aw_pend_nxt;
      w_pend  <= w_pend_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      rdata_q <= rdata_nxt;
      resp_q  <= resp_nxt;
`ifdef MEM2AXI_WSTRB_EN
      wstrb_q <= wstrb_nxt;
`endif
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt   = state;
    aw_pend_nxt = aw_pend;
    w_pend_nxt  = w_pend;
    we_nxt      = we_q;
    addr_nxt    = addr_q;
    wdata_nxt   = wdata_q;
    rdata_nxt   = rdata_q;
    resp_nxt    = resp_q;
`ifdef MEM2AXI_WSTRB_EN
    wstrb_nxt   = wstrb_q;
`endif

    case (state)
      S_IDLE: begin
        if (i_w_req_valid) begin
          we_nxt    = i_w_req_we;
          addr_nxt  = i_w_req_addr;
          wdata_nxt = i_w_req_wdata;
`ifdef MEM2AXI_WSTRB_EN
          wstrb_nxt = i_w_req_wstrb;
`endif
          if (i_w_req_we) begin
            aw_pend_nxt = 1'b1;
            w_pend_nxt  = 1'b1;
            state_nxt   = S_WR_REQ;
          end else begin
            state_nxt   = S_RD_REQ;
          end
        end
      end

      // AW and W complete independently, in either order
      S_WR_REQ: begin
        if (i_w_awready) aw_pend_nxt = 1'b0;
        if (i_w_wready)  w_pend_nxt  = 1'b0;
        if (!aw_pend_nxt && !w_pend_nxt) state_nxt = S_WR_RESP;
      end

      S_WR_RESP: begin
        if (i_w_bvalid) begin
          resp_nxt  = i_w_bresp;
          rdata_nxt = '0;
          state_nxt = S_CLI_RSP;
        end
      end

      S_RD_REQ: begin
        if (i_w_arready) state_nxt = S_RD_RESP;
      end

      S_RD_RESP: begin
        if (i_w_rvalid) begin
          resp_nxt  = i_w_rresp;
          rdata_nxt = i_w_rdata;
          state_nxt = S_CLI_RSP;
        end
      end

      S_CLI_RSP: begin
        if (i_w_rsp_ready) state_nxt = S_IDLE;
      end

      default: begin
        aw_pend_nxt = 1'b0;
        w_pend_nxt  = 1'b0;
        state_nxt   = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the one-hot state
  assign o_w_req_ready = state[ST_IDLE];
  assign o_w_bready    = state[ST_WR_RESP];
  assign o_w_arvalid   = state[ST_RD_REQ];
  assign o_w_rready    = state[ST_RD_RESP];
  assign o_w_rsp_valid = state[ST_CLI_RSP];
  assign o_w_awvalid   = aw_pend;
  assign o_w_wvalid    = w_pend;

  // Payload outputs come straight from the latched registers
  assign o_w_awaddr    = addr_q;
  assign o_w_araddr    = addr_q;
  assign o_w_wdata     = wdata_q;
`ifdef MEM2AXI_WSTRB_EN
  assign o_w_wstrb     = wstrb_q;
`endif
  assign o_w_rsp_we    = we_q;
  assign o_w_rsp_rdata = rdata_q;
  assign o_w_rsp_resp  = resp_q;

endmodule

// File: tb/tb_mem2axi.sv
// Directed self-checking bench for mem2axi. Inputs change 1 ns after the
// rising edge and outputs are checked at the same point, i.e. they show
// the state registered by the edge just passed.
module tb_mem2axi;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
`ifdef MEM2AXI_WSTRB_EN
  logic [DW/8-1:0] req_wstrb, wstrb;
`endif
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem2axi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_w_aclk      (clk),
    .i_w_areset_n  (rst_n),
    .i_w_req_valid (req_valid),
    .o_w_req_ready (req_ready),
    .i_w_req_we    (req_we),
    .i_w_req_addr  (req_addr),
    .i_w_req_wdata (req_wdata),
`ifdef MEM2AXI_WSTRB_EN
    .i_w_req_wstrb (req_wstrb),
`endif
    .o_w_rsp_valid (rsp_valid),
    .i_w_rsp_ready (rsp_ready),
    .o_w_rsp_we    (rsp_we),
    .o_w_rsp_rdata (rsp_rdata),
    .o_w_rsp_resp  (rsp_resp),
    .o_w_awvalid   (awvalid),
    .i_w_awready   (awready),
    .o_w_awaddr    (awaddr),
    .o_w_wvalid    (wvalid),
    .i_w_wready    (wready),
    .o_w_wdata     (wdata),
`ifdef MEM2AXI_WSTRB_EN
    .o_w_wstrb     (wstrb),
`endif
    .i_w_bvalid    (bvalid),
    .o_w_bready    (bready),
    .i_w_bresp     (bresp),
    .o_w_arvalid   (arvalid),
    .i_w_arready   (arready),
    .o_w_araddr    (araddr),
    .i_w_rvalid    (rvalid),
    .o_w_rready    (rready),
    .i_w_rresp     (rresp),
    .i_w_rdata     (rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef MEM2AXI_WSTRB_EN
    req_wstrb = '1;
`endif
    rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;

    // ---- reset state
    tick(); tick();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_awvalid",   64'(awvalid),   64'(0));
    chk("rst_wvalid",    64'(wvalid),    64'(0));
    chk("rst_arvalid",   64'(arvalid),   64'(0));
    chk("rst_bready",    64'(bready),    64'(0));
    chk("rst_rready",    64'(rready),    64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rsp_resp",  64'(rsp_resp),  64'(0));
    chk("rst_awaddr",    64'(awaddr),    64'(0));
    rst_n = 1'b1;
    tick();

    // ---- write, zero wait
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hDEAD_BEEF;
    awready = 1'b1; wready = 1'b1;
    tick();                                   // accept at cycle 0
    req_valid = 1'b0;
    chk("w0_awvalid_c1", 64'(awvalid), 64'(1));
    chk("w0_wvalid_c1",  64'(wvalid),  64'(1));
    chk("w0_awaddr",     64'(awaddr),  64'h10);
    chk("w0_wdata",      64'(wdata),   64'hDEAD_BEEF);
    chk("w0_req_ready",  64'(req_ready), 64'(0));
    tick();                                   // AW/W handshake at cycle 1
    chk("w0_awvalid_c2", 64'(awvalid), 64'(0));
    chk("w0_wvalid_c2",  64'(wvalid),  64'(0));
    chk("w0_bready_c2",  64'(bready),  64'(1));
    bvalid = 1'b1; bresp = 2'b00;
    tick();                                   // B at cycle 2
    bvalid = 1'b0;
    chk("w0_rsp_valid_c3", 64'(rsp_valid), 64'(1));
    chk("w0_rsp_we",       64'(rsp_we),    64'(1));
    chk("w0_rsp_resp",     64'(rsp_resp),  64'(0));
    chk("w0_rsp_rdata",    64'(rsp_rdata), 64'(0));
    chk("w0_bready_c3",    64'(bready),    64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w0_rsp_done",  64'(rsp_valid), 64'(0));
    chk("w0_idle",      64'(req_ready), 64'(1));

    // ---- write, W before AW; also SLVERR passthrough on B
    awready = 1'b0; wready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0010; req_wdata = 32'hCAFE_F00D;
    tick();                                   // cycle 0
    req_valid = 1'b0;
    wready = 1'b1;
    chk("w1_awvalid_c1", 64'(awvalid), 64'(1));
    chk("w1_wvalid_c1",  64'(wvalid),  64'(1));
    tick();                                   // W handshake at cycle 1
    wready = 1'b0;
    chk("w1_wvalid_c2",  64'(wvalid),  64'(0));
    chk("w1_awvalid_c2", 64'(awvalid), 64'(1));
    chk("w1_awaddr_c2",  64'(awaddr),  64'h10);
    chk("w1_bready_c2",  64'(bready),  64'(0));
    tick();
    chk("w1_awvalid_c3", 64'(awvalid), 64'(1));
    tick();
    awready = 1'b1;
    chk("w1_awvalid_c4", 64'(awvalid), 64'(1));
    chk("w1_awaddr_c4",  64'(awaddr),  64'h10);
    tick();                                   // AW handshake at cycle 4
    awready = 1'b0;
    chk("w1_awvalid_c5", 64'(awvalid), 64'(0));
    chk("w1_bready_c5",  64'(bready),  64'(1));
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk("w1_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("w1_rsp_resp",  64'(rsp_resp),  64'(2));
    chk("w1_rsp_rdata", 64'(rsp_rdata), 64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_single_rsp", 64'(rsp_valid), 64'(0));
    tick();
    chk("w1_no_repeat",  64'(rsp_valid), 64'(0));

    // ---- read with backpressure
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0020;
    tick();                                   // cycle 0
    req_valid = 1'b0;
    chk("r0_arvalid_c1", 64'(arvalid), 64'(1));
    chk("r0_araddr",     64'(araddr),  64'h20);
    tick();
    chk("r0_arvalid_c2", 64'(arvalid), 64'(1));
    tick();
    arready = 1'b1;
    tick();                                   // AR handshake at cycle 3
    arready = 1'b0;
    chk("r0_arvalid_c4", 64'(arvalid), 64'(0));
    chk("r0_rready_c4",  64'(rready),  64'(1));
    tick();
    tick();
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    tick();                                   // R at cycle 6
    rvalid = 1'b0; rdata = '0;
    chk("r0_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("r0_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
    chk("r0_rsp_we",    64'(rsp_we),    64'(0));
    chk("r0_rsp_resp",  64'(rsp_resp),  64'(0));
    chk("r0_rready_off", 64'(rready),   64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r0_hold_valid", 64'(rsp_valid), 64'(1));
      chk("r0_hold_rdata", 64'(rsp_rdata), 64'h1234_5678);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r0_rsp_done", 64'(rsp_valid), 64'(0));

    // ---- read returning DECERR
    arready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0030;
    tick();
    req_valid = 1'b0;
    chk("r1_arvalid", 64'(arvalid), 64'(1));
    tick();
    chk("r1_rready",  64'(rready),  64'(1));
    rvalid = 1'b1; rresp = 2'b11; rdata = 32'hA5A5_A5A5;
    tick();
    rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    chk("r1_rsp_resp",  64'(rsp_resp),  64'(3));
    chk("r1_rsp_rdata", 64'(rsp_rdata), 64'hA5A5_A5A5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    arready = 1'b0;

    // ---- stray bvalid/rvalid in IDLE are ignored
    bvalid = 1'b1; rvalid = 1'b1;
    tick();
    chk("stray_bready",   64'(bready),    64'(0));
    chk("stray_rready",   64'(rready),    64'(0));
    chk("stray_rspvalid", 64'(rsp_valid), 64'(0));
    chk("stray_idle",     64'(req_ready), 64'(1));
    bvalid = 1'b0; rvalid = 1'b0;

    // ---- reset in WR_RESP
    awready = 1'b1; wready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h5555_AAAA;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstm_bready", 64'(bready), 64'(1));
    rst_n = 1'b0;
    tick();
    chk("rstm_bready_off", 64'(bready),    64'(0));
    chk("rstm_awvalid",    64'(awvalid),   64'(0));
    chk("rstm_wvalid",     64'(wvalid),    64'(0));
    chk("rstm_rsp_valid",  64'(rsp_valid), 64'(0));
    chk("rstm_req_ready",  64'(req_ready), 64'(1));
    chk("rstm_awaddr",     64'(awaddr),    64'(0));
    chk("rstm_wdata",      64'(wdata),     64'(0));
    rst_n = 1'b1;
    awready = 1'b0; wready = 1'b0;
    tick();
    chk("rstm_still_idle", 64'(req_ready), 64'(1));

    // ---- back-to-back reads with req_valid held high
    arready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0000;
    tick();                                   // first accepted
    req_addr = 32'h0000_0004;
    chk("bb_busy",     64'(req_ready), 64'(0));
    chk("bb_araddr_a", 64'(araddr),    64'h0);
    tick();
    chk("bb_rready_a", 64'(rready), 64'(1));
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("bb_rdata_a",     64'(rsp_rdata), 64'h1111_1111);
    chk("bb_busy_rsp",    64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    tick();                                   // response handshake only
    rsp_ready = 1'b0;
    chk("bb_idle_again",  64'(req_ready), 64'(1));
    chk("bb_no_same_cyc", 64'(arvalid),   64'(0));
    tick();                                   // second accepted
    req_valid = 1'b0;
    chk("bb_arvalid_b", 64'(arvalid), 64'(1));
    chk("bb_araddr_b",  64'(araddr),  64'h4);
    tick();
    rvalid = 1'b1; rdata = 32'h2222_2222;
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("bb_rspvalid_b", 64'(rsp_valid), 64'(1));
    chk("bb_rdata_b",    64'(rsp_rdata), 64'h2222_2222);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    arready = 1'b0;
    chk("bb_end_idle", 64'(req_ready), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem2axi.md
Name: mem2axi

Overview:
- AXI4-Lite master (initiator) bridge: converts a simple single-beat memory-style request/response interface into AXI4-Lite AW/W/B and AR/R transactions.
- It is the counterpart of the existing AXI-slave-to-memory block. A core or DMA front end uses it to reach any AXI4-Lite slave.
- One transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, request and AXI address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.

Ports:
- i_w_aclk  in  1  clock
- i_w_areset_n  in  1  reset; synchronous, active-low
- i_w_req_valid  in  1  client request valid
- o_w_req_ready  out  1  bridge can accept a request
- i_w_req_we  in  1  1 = write, 0 = read
- i_w_req_addr  in  ADDR_WIDTH  byte address
- i_w_req_wdata  in  DATA_WIDTH  write data
- o_w_rsp_valid  out  1  response valid
- i_w_rsp_ready  in  1  client accepts response
- o_w_rsp_we  out  1  echo of the request type
- o_w_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- o_w_rsp_resp  out  2  BRESP/RRESP (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11)
- o_w_awvalid / i_w_awready / o_w_awaddr[ADDR_WIDTH]  AW channel
- o_w_wvalid / i_w_wready / o_w_wdata[DATA_WIDTH]  W channel
- i_w_bvalid / o_w_bready / i_w_bresp[2]  B channel
- o_w_arvalid / i_w_arready / o_w_araddr[ADDR_WIDTH]  AR channel
- i_w_rvalid / o_w_rready / i_w_rresp[2] / i_w_rdata[DATA_WIDTH]  R channel

Behaviour:
- Reset (i_w_areset_n low at a clock edge):
  - State = IDLE.
  - All valid/ready outputs = 0, except o_w_req_ready, which is 1 in IDLE.
  - All address, data and response registers = 0.
  - Reset mid-transaction aborts it silently; the AXI slave is assumed reset by the same reset.
- Registered outputs: all outputs are registered or decoded from one-hot state only; there is no combinational path from AXI inputs to AXI outputs.
- Request accept:
  - o_w_req_ready = 1 only in IDLE.
  - An accept (req_valid & req_ready) latches we/addr/wdata.
  - Address is passed unmodified; slaves ignore the low bits.
- States (one-hot): IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, CLI_RSP.
- IDLE:
  - Accept with we=1 -> WR_REQ; awvalid and wvalid both set the next cycle.
  - Accept with we=0 -> RD_REQ; arvalid set the next cycle.
- WR_REQ:
  - awvalid and wvalid each drop independently on their own handshake; there is no ordering requirement between AW and W.
  - Addr/data stay stable while valid is high.
  - Once both handshakes are done (same or different cycles) -> WR_RESP.
- WR_RESP:
  - o_w_bready = 1.
  - On bvalid: capture bresp, rdata := 0 -> CLI_RSP.
- RD_REQ: arvalid held until arready -> RD_RESP.
- RD_RESP:
  - o_w_rready = 1.
  - On rvalid: capture rdata and rresp -> CLI_RSP.
- CLI_RSP:
  - o_w_rsp_valid = 1; rsp fields stable until i_w_rsp_ready.
  - On i_w_rsp_ready -> IDLE.
  - No new request is accepted in the same cycle.
- Zero-wait latency:
  - Write: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- Error responses (SLVERR/DECERR) are passed through unchanged; the bridge takes no other action.
- AXI valid signals never deassert before their handshake (AXI rule).
- Unexpected inputs: bvalid or rvalid in any state other than WR_RESP/RD_RESP is ignored (the matching ready is 0 there).

Optional Feature:
- Macro: MEM2AXI_WSTRB_EN.
- Defined:
  - Adds input i_w_req_wstrb[DATA_WIDTH/8] and output o_w_wstrb[DATA_WIDTH/8].
  - Strobe is latched with the request and driven with W.
  - A write whose strobe is all-zero is still issued on AXI.
- Undefined:
  - Neither port exists.
  - All bytes are written; the slave is expected to treat a missing WSTRB as all-ones.

Decomposition:
- Shared package: response encodings OKAY/EXOKAY/SLVERR/DECERR, the one-hot state localparams, and the AXI-Lite channel widths.
- These encodings are shared with the slave-side memory bridge.
- No sub-module; one FSM file of roughly 200 lines.

Test Plan:
- Write, zero wait: req we=1, addr=0x0000_0010, wdata=0xDEAD_BEEF; slave ready constant, bresp=00 -> AW/W handshake at cycle 1, rsp_valid at cycle 3 with resp=00, rdata=0.
- Write, W before AW: wready=1 at cycle 1, awready delayed to cycle 4 -> wvalid drops after cycle 1; awaddr=0x10 held until cycle 4; single response afterwards.
- Read with backpressure: addr=0x20, arready at cycle 3, rvalid at cycle 6 with rdata=0x1234_5678, rresp=00 -> rsp_rdata=0x1234_5678, held stable while rsp_ready=0 for 3 cycles.
- Error passthrough: read returns rresp=11 (DECERR) -> rsp_resp=11.
- Reset mid-transaction: reset asserted in WR_RESP -> all valid outputs 0 next edge, state IDLE, req_ready=1.
- Back-to-back: two reads to 0x0 and 0x4 with req_valid held high -> second accepted only after the first rsp handshake; both return correct data.
